// File: rtl/fft_bf_sequencer_if.sv
// Descriptor/handshake bundle between the FFT butterfly sequencer and its datapath.
// The sequencer side uses master; the datapath or a bench uses slave.
interface fft_bf_sequencer_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       bf_valid;
  logic       bf_ready;
  logic [3:0] addr_a;
  logic [3:0] addr_b;
  logic [3:0] tw_addr;
  logic [1:0] stage;
  logic       last_bf;

  modport master (
    input  start, bf_ready,
    output busy, done, bf_valid, addr_a, addr_b, tw_addr, stage, last_bf
  );

  modport slave (
    output start, bf_ready,
    input  busy, done, bf_valid, addr_a, addr_b, tw_addr, stage, last_bf
  );
endinterface

// File: rtl/fft_bf_sequencer.sv
// Butterfly sequencer for a 16-point radix-2 DIT FFT.
// It issues 4 stages x 8 butterfly descriptors and leaves a drain gap after each stage.
module fft_bf_sequencer #(
  parameter int PIPE_LAT = 3,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft_bf_sequencer_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_LAT - 1);

  state_t           state_q, state_d;
  logic [1:0]       stage_q, stage_d;
  logic [2:0]       k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bf_valid_q, bf_valid_d;
  logic             last_bf_q, last_bf_d;
  logic [3:0]       addr_a_q, addr_a_d;
  logic [3:0]       addr_b_q, addr_b_d;
  logic [3:0]       tw_addr_q, tw_addr_d;

  // Returns {addr_a, addr_b, tw_addr} for butterfly k of stage s.
  function automatic logic [11:0] bf_addr(input logic [1:0] s, input logic [2:0] k);
    logic [3:0] k4;
    logic [3:0] span;
    logic [3:0] pos;
    logic [3:0] grp;
    logic [3:0] a;
    k4   = {1'b0, k};
    span = 4'd1 << s;
    pos  = k4 & (span - 4'd1);
    grp  = k4 >> s;
    a    = ((grp << s) << 1'b1) | pos;
    return {a, a + span, pos << (2'd3 - s)};
  endfunction

  // Next-state, counters, and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ISSUE;
          stage_d = 2'd0;
          k_d     = 3'd0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!bus.bf_ready) begin
          state_d = S_ISSUE;
        end else if (k_q != 3'd7) begin
          k_d = k_q + 3'd1;
        end else if (PIPE_LAT != 0) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else if (stage_q != 2'd3) begin
          stage_d = stage_q + 2'd1;
          k_d     = 3'd0;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DRAIN: begin
        if (cnt_q != DRAIN_LAST) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (stage_q != 2'd3) begin
          state_d = S_ISSUE;
          stage_d = stage_q + 2'd1;
          k_d     = 3'd0;
          cnt_d   = '0;
        end else begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        k_d     = 3'd0;
      end
      default: begin
        state_d = S_IDLE;
        stage_d = 2'd0;
        k_d     = 3'd0;
        cnt_d   = '0;
      end
    endcase

    // Descriptor fields follow the next k/stage, so they stay put across a stall.
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    bf_valid_d = (state_d == S_ISSUE);
    last_bf_d  = (state_d == S_ISSUE) && (k_d == 3'd7);
    {addr_a_d, addr_b_d, tw_addr_d} = bf_addr(stage_d, k_d);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      stage_q    <= 2'd0;
      k_q        <= 3'd0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bf_valid_q <= 1'b0;
      last_bf_q  <= 1'b0;
      addr_a_q   <= 4'd0;
      addr_b_q   <= 4'd0;
      tw_addr_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bf_valid_q <= bf_valid_d;
      last_bf_q  <= last_bf_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      tw_addr_q  <= tw_addr_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bf_valid = bf_valid_q;
  assign bus.last_bf  = last_bf_q;
  assign bus.addr_a   = addr_a_q;
  assign bus.addr_b   = addr_b_q;
  assign bus.tw_addr  = tw_addr_q;
  assign bus.stage    = stage_q;

endmodule

// File: tb/tb_fft_bf_sequencer.sv
// Bench for fft_bf_sequencer: two instances (PIPE_LAT=3 and PIPE_LAT=0) checked against
// a descriptor table computed from the FFT addressing rules plus a transfer/drain model.
module tb_fft_bf_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic start_v = 1'b0;
  logic ready_v = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   exp_a [32];
  int   exp_b [32];
  int   exp_tw[32];

  always #5 clk = ~clk;

  fft_bf_sequencer_if if0 ();
  fft_bf_sequencer_if if1 ();

  assign if0.start    = start_v & ~sel;
  assign if1.start    = start_v & sel;
  assign if0.bf_ready = ready_v;
  assign if1.bf_ready = ready_v;

  fft_bf_sequencer #(.PIPE_LAT(3), .CNT_W(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
  fft_bf_sequencer #(.PIPE_LAT(0), .CNT_W(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));

  logic       o_busy, o_done, o_valid, o_last;
  logic [3:0] o_a, o_b, o_tw;
  logic [1:0] o_stage;
  assign o_busy  = sel ? if1.busy     : if0.busy;
  assign o_done  = sel ? if1.done     : if0.done;
  assign o_valid = sel ? if1.bf_valid : if0.bf_valid;
  assign o_last  = sel ? if1.last_bf  : if0.last_bf;
  assign o_a     = sel ? if1.addr_a   : if0.addr_a;
  assign o_b     = sel ? if1.addr_b   : if0.addr_b;
  assign o_tw    = sel ? if1.tw_addr  : if0.tw_addr;
  assign o_stage = sel ? if1.stage    : if0.stage;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  o_busy,  0);
    chk({tag, "_done"},  o_done,  0);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_last"},  o_last,  0);
    chk({tag, "_a"},     o_a,     0);
    chk({tag, "_b"},     o_b,     0);
    chk({tag, "_tw"},    o_tw,    0);
    chk({tag, "_stage"}, o_stage, 0);
  endtask

  // Caller is at a negedge; start is raised here (cycle 0). s1/s2: extra start pulse cycles.
  task automatic run_pass(input bit rnd, input int s1, input int s2,
                          output int done_cyc, output int xfers);
    int idx;
    int drain_left;
    int lat;
    bit seen_done;
    idx = 0; drain_left = 0; seen_done = 1'b0; xfers = 0; done_cyc = -1;
    lat = sel ? 0 : 3;
    start_v = 1'b1;
    ready_v = 1'b1;
    for (int cyc = 1; cyc <= 500 && !seen_done; cyc++) begin
      @(negedge clk);
      start_v = (cyc == s1) || (cyc == s2);
      chk("busy", o_busy, 1);
      if (idx == 32 && drain_left == 0) begin
        chk("done_pulse", o_done, 1);
        chk("valid_in_done", o_valid, 0);
        chk("stage_in_done", o_stage, 3);
        seen_done = 1'b1;
        done_cyc  = cyc;
      end else if (drain_left > 0) begin
        chk("valid_in_drain", o_valid, 0);
        chk("done_early", o_done, 0);
        chk("stage_in_drain", o_stage, (idx - 1) / 8);
        drain_left--;
      end else begin
        chk("valid", o_valid, 1);
        chk("done_early", o_done, 0);
        chk("addr_a", o_a, exp_a[idx]);
        chk("addr_b", o_b, exp_b[idx]);
        chk("tw_addr", o_tw, exp_tw[idx]);
        chk("stage", o_stage, idx / 8);
        chk("last_bf", o_last, (idx % 8) == 7);
        if (idx == 7)  begin chk("s0k7_a", o_a, 14); chk("s0k7_b", o_b, 15); chk("s0k7_tw", o_tw, 0); end
        if (idx == 21) begin chk("s2k5_a", o_a, 9);  chk("s2k5_b", o_b, 13); chk("s2k5_tw", o_tw, 2); end
        if (idx == 27) begin chk("s3k3_a", o_a, 3);  chk("s3k3_b", o_b, 11); chk("s3k3_tw", o_tw, 3); end
        ready_v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (ready_v) begin
          idx++;
          xfers++;
          if (idx % 8 == 0) drain_left = lat;
        end
      end
    end
    chk("done_within_budget", seen_done, 1);
    ready_v = 1'b1;
  endtask

  initial begin
    int dc;
    int nx;
    int dn;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 8; k++) begin
        int span;
        span = 1 << s;
        exp_a[s*8+k]  = (k / span) * 2 * span + (k % span);
        exp_b[s*8+k]  = exp_a[s*8+k] + span;
        exp_tw[s*8+k] = (k % span) * (8 / span);
      end
    end

    // Reset state of both instances
    repeat (3) @(negedge clk);
    chk_all_zero("rst0");
    sel = 1'b1; #1;
    chk_all_zero("rst1");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", o_busy, 0);

    // Nominal pass, starts at 5 (ISSUE) and 45 (DONE) must be ignored
    run_pass(1'b0, 5, 45, dc, nx);
    chk("done_cycle_lat3", dc, 45);
    chk("xfers_lat3", nx, 32);
    @(negedge clk);
    start_v = 1'b0;
    chk("idle46_busy", o_busy, 0);
    chk("idle46_done", o_done, 0);
    chk("idle46_valid", o_valid, 0);

    // Start at 46 (IDLE) launches a second pass, under random backpressure
    run_pass(1'b1, -1, -1, dc, nx);
    chk("xfers_bp", nx, 32);
    @(negedge clk);
    start_v = 1'b0;
    chk("bp_idle_busy", o_busy, 0);

    // Reset in the middle of the stage-1 drain
    repeat (3) @(negedge clk);
    start_v = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start_v = 1'b0;
    end
    chk("c20_busy", o_busy, 1);
    chk("c20_in_drain", o_valid, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_all_zero("midrst");
    dn = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (o_done || o_busy) dn++;
    end
    chk("no_activity_after_rst", dn, 0);
    run_pass(1'b0, -1, -1, dc, nx);
    chk("done_cycle_after_rst", dc, 45);
    chk("xfers_after_rst", nx, 32);
    @(negedge clk);
    start_v = 1'b0;

    // PIPE_LAT=0 instance: 32 contiguous valid cycles, done at 33
    repeat (2) @(negedge clk);
    sel = 1'b1;
    #1;
    chk("lat0_idle_busy", o_busy, 0);
    run_pass(1'b0, -1, -1, dc, nx);
    chk("done_cycle_lat0", dc, 33);
    chk("xfers_lat0", nx, 32);
    @(negedge clk);
    start_v = 1'b0;
    chk("lat0_idle_after", o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
